// File: rtl/fetch_unit_pkg.sv
// Shared types for the instruction fetch unit: FSM states, buffer entry layout
// and the canonical NOP encoding.
package fetch_unit_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    REQ  = 2'd1,
    WAIT = 2'd2
  } fetch_state_e;

  localparam logic [31:0] INSN_NOP = 32'h0000_0013;

  typedef struct packed {
    logic [31:0] insn;
    logic [31:0] pc;
  } fetch_entry_t;

  // Force a fetch target onto a word boundary.
  function automatic logic [31:0] align_pc(input logic [31:0] addr);
    return addr & ~32'h0000_0003;
  endfunction

endpackage

// File: rtl/fetch_unit_fifo.sv
// Synchronous instruction buffer with zero-latency head output; a pop frees
// the slot a same-cycle push needs, so push+pop while full keeps occupancy.
module fetch_fifo
  import fetch_unit_pkg::*;
#(
  parameter int DEPTH = 2
) (
  input  logic                   i_clk,
  input  logic                   i_reset,
  input  logic                   i_flush,
  input  logic                   i_push,
  input  fetch_entry_t           i_push_data,
  input  logic                   i_pop,
  output fetch_entry_t           o_head,
  output logic [$clog2(DEPTH):0] o_count,
  output logic                   o_full,
  output logic                   o_empty
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  fetch_entry_t  r_mem [DEPTH];
  logic [AW-1:0] r_wr_ptr;
  logic [AW-1:0] r_rd_ptr;
  logic [CW-1:0] r_count;
  logic          w_do_push;
  logic          w_do_pop;

  assign o_full    = (r_count == CW'(DEPTH));
  assign o_empty   = (r_count == '0);
  assign o_count   = r_count;
  assign o_head    = r_mem[r_rd_ptr];
  assign w_do_pop  = i_pop && !o_empty && !i_flush;
  assign w_do_push = i_push && !i_flush && (!o_full || w_do_pop);

  always_ff @(posedge i_clk) begin
    if (w_do_push) r_mem[r_wr_ptr] <= i_push_data;
  end

  // DEPTH is a power of two, so the pointers wrap naturally.
  always_ff @(posedge i_clk) begin
    if (i_reset || i_flush) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_do_push) r_wr_ptr <= r_wr_ptr + AW'(1);
      if (w_do_pop)  r_rd_ptr <= r_rd_ptr + AW'(1);
      r_count <= r_count + CW'(w_do_push) - CW'(w_do_pop);
    end
  end

endmodule

// File: rtl/fetch_unit.sv
// Instruction fetch: one outstanding request, credit-gated by buffer space,
// redirect flushes and marks any in-flight word stale. Option: FETCH_MISALIGN_TRAP_EN.
//   state | meaning
//   IDLE  | first cycle out of reset
//   REQ   | request presented when credits allow
//   WAIT  | one request outstanding, awaiting imem_rvalid
module fetch_unit
  import fetch_unit_pkg::*;
#(
  parameter logic [31:0] RESET_PC   = 32'h0000_0000,
  parameter int          FIFO_DEPTH = 2
) (
  input  logic        clk,
  input  logic        reset,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_ready,
  input  logic        imem_rvalid,
  input  logic [31:0] imem_rdata,
  output logic        insn_valid,
  input  logic        insn_ready,
  output logic [31:0] insn,
  output logic [31:0] pc,
  input  logic        redirect,
  input  logic [31:0] redirect_pc,
  output logic        fetch_fault
);

  localparam int CW = $clog2(FIFO_DEPTH) + 1;

  fetch_state_e  r_state;
  logic [31:0]   r_fetch_pc;
  logic [31:0]   r_req_addr;
  logic          r_stale;
  logic          w_fault;
  logic          w_accept;
  logic          w_push;
  logic          w_pop;
  logic          w_full;
  logic          w_empty;
  logic          w_has_credit;
  logic [CW-1:0] w_count;
  logic [CW-1:0] w_free;
  logic [CW-1:0] w_outstanding;
  logic [31:0]   w_redirect_pc;
  fetch_entry_t  w_push_entry;
  fetch_entry_t  w_head;

`ifdef FETCH_MISALIGN_TRAP_EN
  logic r_fault;

  always_ff @(posedge clk) begin
    if (reset)         r_fault <= 1'b0;
    else if (redirect) r_fault <= |redirect_pc[1:0];
  end

  assign w_fault = r_fault;
`else
  assign w_fault = 1'b0;
`endif

  assign fetch_fault   = w_fault;
  assign w_redirect_pc = align_pc(redirect_pc);

  // Credits reserve a slot for the in-flight word so the push can never overflow.
  assign w_free        = CW'(FIFO_DEPTH) - w_count;
  assign w_outstanding = CW'(r_state == WAIT);
  assign w_has_credit  = !w_full && (w_free > w_outstanding);

  assign imem_req  = (r_state == REQ) && w_has_credit && !w_fault;
  assign imem_addr = r_fetch_pc;
  assign w_accept  = imem_req && imem_ready;

  assign w_push       = (r_state == WAIT) && imem_rvalid && !r_stale && !redirect;
  assign w_pop        = insn_valid && insn_ready && !redirect;
  assign w_push_entry = '{insn: imem_rdata, pc: r_req_addr};

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state    <= IDLE;
      r_fetch_pc <= RESET_PC;
      r_req_addr <= '0;
      r_stale    <= 1'b0;
    end else begin
      case (r_state)
        IDLE: r_state <= REQ;
        REQ: begin
          if (w_accept) begin
            r_state    <= WAIT;
            r_req_addr <= r_fetch_pc;
            r_fetch_pc <= r_fetch_pc + 32'd4;
            r_stale    <= redirect;
          end
        end
        WAIT: begin
          if (imem_rvalid) begin
            r_state <= REQ;
            r_stale <= 1'b0;
          end else if (redirect) begin
            r_stale <= 1'b1;
          end
        end
        default: r_state <= IDLE;
      endcase
      if (redirect) r_fetch_pc <= w_redirect_pc;
    end
  end

  fetch_fifo #(
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .i_clk       (clk),
    .i_reset     (reset),
    .i_flush     (redirect),
    .i_push      (w_push),
    .i_push_data (w_push_entry),
    .i_pop       (w_pop),
    .o_head      (w_head),
    .o_count     (w_count),
    .o_full      (w_full),
    .o_empty     (w_empty)
  );

  assign insn_valid = !w_empty;
  assign insn       = w_empty ? 32'h0 : w_head.insn;
  assign pc         = w_empty ? 32'h0 : w_head.pc;

endmodule

// File: tb/tb_fetch_unit.sv
// Scoreboard bench for fetch_unit: directed phases push expected {insn, pc}
// into queues, negedge monitors pop and compare on every decoder handshake.
module tb_fetch_unit;
  import fetch_unit_pkg::*;

  logic        clk;
  logic        reset;
  logic        imem_req, imem_ready, imem_rvalid;
  logic [31:0] imem_addr, imem_rdata;
  logic        insn_valid, insn_ready;
  logic [31:0] insn, pc;
  logic        redirect;
  logic [31:0] redirect_pc;
  logic        fetch_fault;

  logic        wr_imem_req, wr_imem_rvalid, wr_insn_valid, wr_insn_ready, wr_fetch_fault;
  logic [31:0] wr_imem_addr, wr_imem_rdata, wr_insn, wr_pc;

  int n_checks = 0;
  int n_fail   = 0;
  int n_pop    = 0;
  int n_pop_w  = 0;
  logic mem_hold;

  fetch_entry_t exp_q[$];
  fetch_entry_t exp_qw[$];
  logic [31:0]  mem_q[$];

  fetch_unit #(.RESET_PC(32'h0000_0000), .FIFO_DEPTH(2)) dut (
    .clk(clk), .reset(reset),
    .imem_req(imem_req), .imem_addr(imem_addr), .imem_ready(imem_ready),
    .imem_rvalid(imem_rvalid), .imem_rdata(imem_rdata),
    .insn_valid(insn_valid), .insn_ready(insn_ready), .insn(insn), .pc(pc),
    .redirect(redirect), .redirect_pc(redirect_pc), .fetch_fault(fetch_fault)
  );

  fetch_unit #(.RESET_PC(32'hFFFF_FFFC), .FIFO_DEPTH(2)) dut_w (
    .clk(clk), .reset(reset),
    .imem_req(wr_imem_req), .imem_addr(wr_imem_addr), .imem_ready(1'b1),
    .imem_rvalid(wr_imem_rvalid), .imem_rdata(wr_imem_rdata),
    .insn_valid(wr_insn_valid), .insn_ready(wr_insn_ready), .insn(wr_insn), .pc(wr_pc),
    .redirect(1'b0), .redirect_pc(32'h0), .fetch_fault(wr_fetch_fault)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return {a[15:0], 16'hC0DE};
  endfunction

  function automatic void check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h", nm, act, exp);
    end
  endfunction

  function automatic void expect_entry(input logic [31:0] i, input logic [31:0] p);
    exp_q.push_back('{insn: i, pc: p});
  endfunction

  // One clock: capture the request the edge will accept, then drive the
  // memory responses for the new cycle (1-cycle latency unless held).
  task automatic tick();
    logic        acc, acc_w;
    logic [31:0] a, a_w;
    acc   = imem_req && imem_ready;
    a     = imem_addr;
    acc_w = wr_imem_req;
    a_w   = wr_imem_addr;
    @(posedge clk);
    #1;
    if (acc) mem_q.push_back(a);
    imem_rvalid = 1'b0;
    imem_rdata  = 32'h0;
    if (!mem_hold && mem_q.size() > 0) begin
      imem_rvalid = 1'b1;
      imem_rdata  = mem_word(mem_q.pop_front());
    end
    wr_imem_rvalid = acc_w;
    wr_imem_rdata  = acc_w ? mem_word(a_w) : 32'h0;
    if (n_pop_w >= 2) wr_insn_ready = 1'b0;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    tick();
    tick();
    reset = 1'b0;
  endtask

  task automatic wait_pops(input int target, input string nm);
    int k = 0;
    while (n_pop < target && k < 60) begin
      tick();
      k++;
    end
    if (n_pop < target) check({nm, "_timeout"}, 32'(n_pop), 32'(target));
  endtask

  always @(negedge clk) begin
    if (!reset && insn_valid && insn_ready && !redirect) begin
      fetch_entry_t e;
      n_pop++;
      if (exp_q.size() == 0) begin
        n_checks++;
        n_fail++;
        $display("FAIL unexpected_pop: got pc %h insn %h, expected no handshake", pc, insn);
      end else begin
        e = exp_q.pop_front();
        check("pop_pc", pc, e.pc);
        check("pop_insn", insn, e.insn);
      end
    end
  end

  always @(negedge clk) begin
    if (!reset && wr_insn_valid && wr_insn_ready) begin
      fetch_entry_t e;
      n_pop_w++;
      if (exp_qw.size() == 0) begin
        n_checks++;
        n_fail++;
        $display("FAIL wrap_unexpected_pop: got pc %h, expected no handshake", wr_pc);
      end else begin
        e = exp_qw.pop_front();
        check("wrap_pc", wr_pc, e.pc);
        check("wrap_insn", wr_insn, e.insn);
      end
    end
  end

  initial begin
    int k;
    reset = 1'b1; imem_ready = 1'b1; imem_rvalid = 1'b0; imem_rdata = 32'h0;
    insn_ready = 1'b0; redirect = 1'b0; redirect_pc = 32'h0; mem_hold = 1'b0;
    wr_imem_rvalid = 1'b0; wr_imem_rdata = 32'h0; wr_insn_ready = 1'b1;

    // reset state
    do_reset();
    reset = 1'b1;
    check("rst_imem_req", 32'(imem_req), 32'd0);
    check("rst_insn_valid", 32'(insn_valid), 32'd0);
    check("rst_insn", insn, 32'h0);
    check("rst_pc", pc, 32'h0);
    check("rst_fetch_fault", 32'(fetch_fault), 32'd0);

    // stream, plus wrap-around on the second instance
    expect_entry(32'h0000_C0DE, 32'h0000_0000);
    expect_entry(32'h0004_C0DE, 32'h0000_0004);
    expect_entry(32'h0008_C0DE, 32'h0000_0008);
    expect_entry(32'h000C_C0DE, 32'h0000_000C);
    exp_qw.push_back('{insn: 32'hFFFC_C0DE, pc: 32'hFFFF_FFFC});
    exp_qw.push_back('{insn: 32'h0000_C0DE, pc: 32'h0000_0000});
    insn_ready = 1'b1;
    reset = 1'b0;
    tick();
    check("first_req", 32'(imem_req), 32'd1);
    check("first_addr", imem_addr, 32'h0000_0000);
    wait_pops(4, "stream");
    insn_ready = 1'b0;
    check("wrap_drained", 32'(exp_qw.size()), 32'd0);

    // back-pressure
    expect_entry(32'h0010_C0DE, 32'h0000_0010);
    expect_entry(32'h0014_C0DE, 32'h0000_0014);
    expect_entry(32'h0018_C0DE, 32'h0000_0018);
    for (int i = 0; i < 10; i++) tick();
    check("bp_count", 32'(dut.u_fifo.r_count), 32'd2);
    check("bp_imem_req", 32'(imem_req), 32'd0);
    check("bp_head_pc", pc, 32'h0000_0010);
    insn_ready = 1'b1;
    wait_pops(7, "backpressure");
    insn_ready = 1'b0;
    check("bp_drained", 32'(exp_q.size()), 32'd0);

    // redirect while a request is outstanding
    do_reset();
    mem_hold = 1'b1;
    insn_ready = 1'b1;
    k = 0;
    while (mem_q.size() == 0 && k < 20) begin tick(); k++; end
    check("wait_reached", 32'(mem_q.size()), 32'd1);
    check("wait_no_req", 32'(imem_req), 32'd0);
    expect_entry(32'h0100_C0DE, 32'h0000_0100);
    redirect = 1'b1; redirect_pc = 32'h0000_0100; mem_hold = 1'b0;
    tick();
    redirect = 1'b0;
    tick();
    check("stale_dropped", 32'(insn_valid), 32'd0);
    check("redir_addr", imem_addr, 32'h0000_0100);
    wait_pops(n_pop + 1, "redirect_wait");
    insn_ready = 1'b0;
    check("redir_drained", 32'(exp_q.size()), 32'd0);

    // redirect coinciding with imem_rvalid and a decoder pop
    do_reset();
    k = 0;
    while (!(imem_rvalid && insn_valid) && k < 20) begin tick(); k++; end
    check("corner_setup", 32'(imem_rvalid && insn_valid), 32'd1);
    expect_entry(32'h0200_C0DE, 32'h0000_0200);
    redirect = 1'b1; redirect_pc = 32'h0000_0200; insn_ready = 1'b1;
    tick();
    redirect = 1'b0;
    check("corner_empty", 32'(insn_valid), 32'd0);
    check("corner_req", 32'(imem_req), 32'd1);
    check("corner_addr", imem_addr, 32'h0000_0200);
    wait_pops(n_pop + 1, "corner");
    insn_ready = 1'b0;
    check("corner_drained", 32'(exp_q.size()), 32'd0);

    // misaligned redirect, landing on an accepted request
    do_reset();
    insn_ready = 1'b1;
    tick();
    redirect = 1'b1; redirect_pc = 32'h0000_0102;
`ifdef FETCH_MISALIGN_TRAP_EN
    tick();
    redirect = 1'b0;
    check("mis_fault_set", 32'(fetch_fault), 32'd1);
    for (int i = 0; i < 5; i++) begin
      tick();
      check("mis_no_req", 32'(imem_req), 32'd0);
    end
    expect_entry(32'h0300_C0DE, 32'h0000_0300);
    redirect = 1'b1; redirect_pc = 32'h0000_0300;
    tick();
    redirect = 1'b0;
    check("mis_fault_clr", 32'(fetch_fault), 32'd0);
`else
    expect_entry(32'h0100_C0DE, 32'h0000_0100);
    tick();
    redirect = 1'b0;
    check("mis_fault_tied", 32'(fetch_fault), 32'd0);
`endif
    wait_pops(n_pop + 1, "misalign");
    insn_ready = 1'b0;
    check("mis_drained", 32'(exp_q.size()), 32'd0);

    // reset while waiting: the late response must not be buffered
    do_reset();
    expect_entry(32'h0000_C0DE, 32'h0000_0000);
    expect_entry(32'h0004_C0DE, 32'h0000_0004);
    insn_ready = 1'b1;
    wait_pops(n_pop + 2, "pre_reset");
    insn_ready = 1'b0;
    mem_hold = 1'b1;
    k = 0;
    while (mem_q.size() == 0 && k < 20) begin tick(); k++; end
    check("midwait_setup", 32'(mem_q.size()), 32'd1);
    reset = 1'b1;
    tick();
    reset = 1'b0;
    mem_hold = 1'b0;
    expect_entry(32'h0000_C0DE, 32'h0000_0000);
    expect_entry(32'h0004_C0DE, 32'h0000_0004);
    insn_ready = 1'b1;
    wait_pops(n_pop + 2, "post_reset");
    insn_ready = 1'b0;
    check("final_drained", 32'(exp_q.size()), 32'd0);
    check("wrap_final_drained", 32'(exp_qw.size()), 32'd0);

    tick();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
